// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply or restoring divide,
// plus single-edge MTHI/MTLO writes and a combinational pipeline stall.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        rd_req,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [4:0]  count_r;
  logic [63:0] acc_r;
  logic [31:0] opa_r;
  logic [31:0] src_r;
  logic [1:0]  op_r;
  logic        neg_a_r;
  logic        neg_b_r;
  logic        dz_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        done_r;

  logic        accept_s;
  logic        sgn_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_sh_s;
  logic [32:0] div_diff_s;
  logic [63:0] step_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    return (en && v[31]) ? (32'd0 - v) : v;
  endfunction

  assign accept_s = (state_r == IDLE) && start && (op[2] == 1'b0);
  assign sgn_s    = ~op[0];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = accept_s ? RUN : IDLE;
      RUN:     state_s = (count_r == 5'd31) ? FIX : RUN;
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode; stall has no added latency
  always_comb begin
    busy  = (state_r != IDLE);
    stall = busy & (start | rd_req);
    done  = done_r;
    hi    = hi_r;
    lo    = lo_r;
  end

  // One iteration step and final sign fix-up; acc holds {rem,quot} for divide
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[63:32]} + {1'b0, opa_r};
    div_sh_s   = {acc_r[63:32], acc_r[31]};
    div_diff_s = div_sh_s - {1'b0, opa_r};
    if (op_r[1]) begin
      if (!div_diff_s[32]) begin
        step_s = {div_diff_s[31:0], acc_r[30:0], 1'b1};
      end else begin
        step_s = {div_sh_s[31:0], acc_r[30:0], 1'b0};
      end
    end else if (acc_r[0]) begin
      step_s = {mul_sum_s, acc_r[31:1]};
    end else begin
      step_s = {1'b0, acc_r[63:1]};
    end
    prod_s = ((op_r == 2'd0) && (neg_a_r ^ neg_b_r)) ? (64'd0 - acc_r) : acc_r;
    quot_s = ((op_r == 2'd2) && (neg_a_r ^ neg_b_r)) ? (32'd0 - acc_r[31:0]) : acc_r[31:0];
    rem_s  = ((op_r == 2'd2) && neg_a_r) ? (32'd0 - acc_r[63:32]) : acc_r[63:32];
    if (!op_r[1]) begin
      fix_hi_s = prod_s[63:32];
      fix_lo_s = prod_s[31:0];
    end else if (dz_r) begin
      fix_hi_s = src_r;
      fix_lo_s = 32'hFFFF_FFFF;
    end else begin
      fix_hi_s = rem_s;
      fix_lo_s = quot_s;
    end
  end

  // Operand latch, iteration datapath, HI/LO and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 5'd0;
      acc_r   <= 64'd0;
      opa_r   <= 32'd0;
      src_r   <= 32'd0;
      op_r    <= 2'd0;
      neg_a_r <= 1'b0;
      neg_b_r <= 1'b0;
      dz_r    <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
      done_r  <= 1'b0;
    end else begin
      done_r <= (state_r == FIX);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r    <= op[1:0];
            neg_a_r <= sgn_s & rs_val[31];
            neg_b_r <= sgn_s & rt_val[31];
            dz_r    <= (rt_val == 32'd0);
            src_r   <= rs_val;
            count_r <= 5'd0;
            if (op[1]) begin
              opa_r <= abs32(rt_val, sgn_s);
              acc_r <= {32'd0, abs32(rs_val, sgn_s)};
            end else begin
              opa_r <= abs32(rs_val, sgn_s);
              acc_r <= {32'd0, abs32(rt_val, sgn_s)};
            end
          end else if (start && (op == 3'd4)) begin
            hi_r <= rs_val;
          end else if (start && (op == 3'd5)) begin
            lo_r <= rs_val;
          end else begin
            count_r <= count_r;
          end
        end
        RUN: begin
          acc_r   <= step_s;
          count_r <= count_r + 5'd1;
        end
        FIX: begin
          hi_r <= fix_hi_s;
          lo_r <= fix_lo_s;
        end
        default: begin
          count_r <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected {hi,lo} queued at issue, compared on done.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        rd_req;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .rd_req(rd_req), .busy(busy), .stall(stall),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference {hi,lo} computed with native arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] da;
    logic signed [31:0] db;
    logic [31:0] q;
    logic [31:0] r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    da = $signed(a);
    db = $signed(b);
    case (o)
      3'd0: return sa * sb;
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = da / db;
        r = da % db;
        return {r, q};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic wait_idle(input logic rd, input logic st);
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      n++;
      check("stall_busy", 64'(stall), 64'(rd | st));
      check("hold_hi", {32'd0, hi}, {32'd0, cur_hi});
      check("hold_lo", {32'd0, lo}, {32'd0, cur_lo});
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'd33);
    check("done_pulse", 64'(done), 64'd1);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] e, input logic rd);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; rd_req = rd;
    #1 check("stall_idle", 64'(stall), 64'd0);
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0; op = 3'd6;
    wait_idle(rd, 1'b0);
    cur_hi = e[63:32];
    cur_lo = e[31:0];
    rd_req = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1; start = 1'b0; op = 3'd6; rs_val = 32'd0; rt_val = 32'd0; rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, {32'h0000_0006, 32'hFFFF_FFEB}, 1'b0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    run_op(3'd3, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 1'b0);

    // DIV overflow case with a second op held on start through the whole busy window
    @(negedge clk);
    start = 1'b1; op = 3'd2; rs_val = 32'h8000_0000; rt_val = 32'hFFFF_FFFF;
    exp_q.push_back({32'd0, 32'h8000_0000});
    @(posedge clk);
    #1 op = 3'd1; rs_val = 32'd5; rt_val = 32'd7;
    exp_q.push_back(64'd35);
    wait_idle(1'b0, 1'b1);
    cur_hi = 32'd0; cur_lo = 32'h8000_0000;
    @(posedge clk);
    #1 check("accept_e34", 64'(busy), 64'd1);
    start = 1'b0; op = 3'd6;
    wait_idle(1'b0, 1'b0);
    cur_hi = 32'd0; cur_lo = 32'd35;

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs_val = 32'h1234_5678;
    @(posedge clk);
    #1 op = 3'd5; rs_val = 32'h9ABC_DEF0;
    @(negedge clk);
    check("mthi_hi", {32'd0, hi}, 64'h1234_5678);
    check("mthi_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 start = 1'b0; op = 3'd6;
    @(negedge clk);
    check("mtlo_lo", {32'd0, lo}, 64'h9ABC_DEF0);
    check("mtlo_hi", {32'd0, hi}, 64'h1234_5678);
    check("mt_busy", 64'(busy), 64'd0);
    check("mt_done", 64'(done), 64'd0);
    cur_hi = 32'h1234_5678; cur_lo = 32'h9ABC_DEF0;
    rd_req = 1'b1;
    #1 check("rd_idle_stall", 64'(stall), 64'd0);
    rd_req = 1'b0;

    // Reset sampled at E10 of a MULTU; nothing queued so a done would be flagged
    @(negedge clk);
    start = 1'b1; op = 3'd1; rs_val = 32'hDEAD_BEEF; rt_val = 32'h1234_5678;
    @(posedge clk);
    #1 start = 1'b0; op = 3'd6;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    cur_hi = 32'd0; cur_lo = 32'd0;
    run_op(3'd0, 32'd2, 32'd3, 64'd6, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ((i == 4) ? 32'($urandom_range(1, 50)) : $urandom);
      run_op(ro, ra, rb, model(ro, ra, rb), i[0]);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
